// File: rtl/multiplicador_seq.sv
// Sequential shift-and-add unsigned multiplier: n iterations through one shared n-bit adder,
// with a registered 2n-bit product and busy/done handshake flags.

module SumaNBit #(
  parameter int unsigned n = 4
) (
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  output logic [n-1:0] Sum,
  output logic         Cout
);

  // Ripple-carry chain kept inside one process so the carry vector has no feedback loop.
  always_comb begin
    logic [n:0] carry;
    carry    = '0;
    Sum      = '0;
    for (int i = 0; i < int'(n); i++) begin
      Sum[i]     = A[i] ^ B[i] ^ carry[i];
      carry[i+1] = (A[i] & B[i]) | (A[i] & carry[i]) | (B[i] & carry[i]);
    end
    Cout = carry[n];
  end

endmodule

module multiplicador_seq #(
  parameter int unsigned n = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [n-1:0]   A,
  input  logic [n-1:0]   B,
  output logic [2*n-1:0] Prod,
  output logic           busy,
  output logic           done
);

  localparam int unsigned CntW = $clog2(n + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(n - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [n-1:0]    mcand_q, mcand_d;
  logic [n-1:0]    acc_hi_q, acc_hi_d;
  logic [n-1:0]    acc_lo_q, acc_lo_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2*n-1:0]  prod_q, prod_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [n-1:0]    add_sum;
  logic            add_cout;
  logic [n-1:0]    step_sum;
  logic            step_c;
  logic [2*n-1:0]  step_acc;

  SumaNBit #(.n(n)) u_add (
    .A    (acc_hi_q),
    .B    (mcand_q),
    .Sum  (add_sum),
    .Cout (add_cout)
  );

  // The adder carry becomes the new top bit of the shifted accumulator.
  always_comb begin
    if (acc_lo_q[0]) begin
      step_c   = add_cout;
      step_sum = add_sum;
    end else begin
      step_c   = 1'b0;
      step_sum = acc_hi_q;
    end
    step_acc = {step_c, step_sum, acc_lo_q[n-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          mcand_d  = A;
          acc_hi_d = '0;
          acc_lo_d = B;
          cnt_d    = '0;
          state_d  = StCalc;
        end
      end
      StCalc: begin
        {acc_hi_d, acc_lo_d} = step_acc;
        cnt_d                = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          prod_d  = step_acc;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    busy_d = (state_d == StCalc);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Prod = prod_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_multiplicador_seq.sv
// Scoreboard bench for multiplicador_seq: expected products are queued at start and
// compared by a monitor on every done pulse; scenario tasks check the handshake timing.

module tb_multiplicador_seq;

  logic        clk;
  logic        rst_n;
  logic        start4, start8;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic [7:0]  prod4;
  logic [15:0] prod8;
  logic        busy4, done4, busy8, done8;

  int total;
  int bad;

  logic [7:0]  q4[$];
  logic [15:0] q8[$];
  logic [7:0]  exp4;
  logic [15:0] exp8;

  multiplicador_seq #(.n(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .A     (a4),
    .B     (b4),
    .Prod  (prod4),
    .busy  (busy4),
    .done  (done4)
  );

  multiplicador_seq #(.n(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .A     (a8),
    .B     (b8),
    .Prod  (prod8),
    .busy  (busy8),
    .done  (done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: each done pulse must match the oldest queued product.
  always @(negedge clk) begin
    if (rst_n && done4) begin
      total++;
      if (q4.size() == 0) begin
        bad++;
        $display("FAIL prod4_unexpected_done got=%h", prod4);
      end else begin
        exp4 = q4.pop_front();
        if (prod4 !== exp4) begin
          bad++;
          $display("FAIL prod4 got=%h exp=%h", prod4, exp4);
        end
      end
    end
    if (rst_n && done8) begin
      total++;
      if (q8.size() == 0) begin
        bad++;
        $display("FAIL prod8_unexpected_done got=%h", prod8);
      end else begin
        exp8 = q8.pop_front();
        if (prod8 !== exp8) begin
          bad++;
          $display("FAIL prod8 got=%h exp=%h", prod8, exp8);
        end
      end
    end
  end

  // Starts one n=4 operation from IDLE and waits for done; returns at a negedge in IDLE.
  task automatic run4(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] p;
    logic seen;
    p = 8'(a) * 8'(b);
    a4 = a; b4 = b; start4 = 1'b1;
    q4.push_back(p);
    @(negedge clk);
    start4 = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      if (done4) seen = 1'b1;
      else @(negedge clk);
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL run4_timeout got=no_done exp=done a=%h b=%h", a, b);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start4 = 1'b0; start8 = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    #3;
    total++;
    if (prod4 !== 8'h00 || busy4 !== 1'b0 || done4 !== 1'b0) begin
      bad++;
      $display("FAIL reset4 got=%h/%b/%b exp=00/0/0", prod4, busy4, done4);
    end
    total++;
    if (prod8 !== 16'h0000 || busy8 !== 1'b0 || done8 !== 1'b0) begin
      bad++;
      $display("FAIL reset8 got=%h/%b/%b exp=0000/0/0", prod8, busy8, done8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    a4 = 4'b0101; b4 = 4'b1100; start4 = 1'b1;
    q4.push_back(8'h3C);
    @(negedge clk);
    start4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (busy4 !== 1'b1 || done4 !== 1'b0 || prod4 !== 8'h00) begin
        bad++;
        $display("FAIL basic_calc%0d got=%b/%b/%h exp=1/0/00", i, busy4, done4, prod4);
      end
      @(negedge clk);
    end
    total++;
    if (busy4 !== 1'b0 || done4 !== 1'b1) begin
      bad++;
      $display("FAIL basic_done got=%b/%b exp=0/1", busy4, done4);
    end
    @(negedge clk);
    total++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || prod4 !== 8'h3C) begin
      bad++;
      $display("FAIL basic_after got=%b/%b/%h exp=0/0/3c", busy4, done4, prod4);
    end
  endtask

  task automatic test_carry_and_zero;
    run4(4'b1111, 4'b1111);
    total++;
    if (prod4 !== 8'hE1) begin
      bad++;
      $display("FAIL carry_hold got=%h exp=e1", prod4);
    end
    run4(4'b1010, 4'b1111);
    run4(4'b0000, 4'b0000);
    total++;
    if (prod4 !== 8'h00) begin
      bad++;
      $display("FAIL zero_hold got=%h exp=00", prod4);
    end
  endtask

  task automatic test_start_held;
    int ndone;
    int t1, t2;
    ndone = 0; t1 = -1; t2 = -1;
    a4 = 4'b0011; b4 = 4'b0011; start4 = 1'b1;
    q4.push_back(8'h09);
    q4.push_back(8'h2D);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) a4 = 4'b1111;
      if (i == 9) start4 = 1'b0;
      if (done4) begin
        ndone++;
        if (ndone == 1) t1 = i;
        else t2 = i;
      end
      if (i == 5) begin
        total++;
        if (busy4 !== 1'b0 || done4 !== 1'b0) begin
          bad++;
          $display("FAIL held_idle_gap got=%b/%b exp=0/0", busy4, done4);
        end
      end
    end
    total++;
    if (ndone != 2 || (t2 - t1) != 6) begin
      bad++;
      $display("FAIL held_done_count got=%0d/%0d exp=2/6", ndone, t2 - t1);
    end
  endtask

  task automatic test_reset_mid;
    int ndone;
    a4 = 4'd7; b4 = 4'd7; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || prod4 !== 8'h00) begin
      bad++;
      $display("FAIL midreset got=%b/%b/%h exp=0/0/00", busy4, done4, prod4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (done4) ndone++;
    end
    total++;
    if (ndone != 0 || prod4 !== 8'h00) begin
      bad++;
      $display("FAIL midreset_nodone got=%0d/%h exp=0/00", ndone, prod4);
    end
    a4 = 4'd7; b4 = 4'd7; start4 = 1'b1;
    q4.push_back(8'h31);
    @(negedge clk);
    start4 = 1'b0;
    total++;
    if (busy4 !== 1'b1) begin
      bad++;
      $display("FAIL restart_accept got=%b exp=1", busy4);
    end
    for (int i = 0; i < 12 && !done4; i++) @(negedge clk);
    total++;
    if (done4 !== 1'b1) begin
      bad++;
      $display("FAIL restart_timeout got=%b exp=1", done4);
    end
    @(negedge clk);
  endtask

  task automatic test_sweep4;
    int cyc;
    start4 = 1'b1;
    for (int k = 0; k < 256; k++) begin
      a4 = 4'(k >> 4); b4 = 4'(k);
      q4.push_back(8'(k >> 4) * 8'(k & 15));
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!done4 && cyc < 20);
      if (k == 255) start4 = 1'b0;
      total++;
      if (!done4 || (k > 0 && cyc != 6)) begin
        bad++;
        $display("FAIL sweep4_period k=%0d got=%0d exp=6", k, cyc);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_sweep8;
    int cyc;
    logic [7:0] a, b;
    start8 = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      if (k == 0) begin
        a = 8'hFF; b = 8'hFF;
      end else begin
        a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
      end
      a8 = a; b8 = b;
      q8.push_back(16'(a) * 16'(b));
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!done8 && cyc < 30);
      if (k == 999) start8 = 1'b0;
      total++;
      if (!done8 || (k > 0 && cyc != 10)) begin
        bad++;
        $display("FAIL sweep8_period k=%0d got=%0d exp=10", k, cyc);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_carry_and_zero();
    test_start_held();
    test_reset_mid();
    test_sweep4();
    test_sweep8();
    repeat (3) @(negedge clk);
    total++;
    if (q4.size() != 0 || q8.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d/%0d exp=0/0", q4.size(), q8.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
